// File: rtl/hazard_ctrl_seq_if.sv
// hazard_ctrl_seq_if: pipeline-to-hazard-controller signal bundle.
// master drives the pipeline-side inputs and observes the controls; slave is the controller.
// Execute/Memory/Writeback inputs: rs_E, rt_E, rd_E, mem_read_E, branch_taken_E, rd_M, reg_write_M, rd_W, reg_write_W.
// Decode inputs: rs_D, rt_D, use_rs_D, use_rt_D, is_2byte_D, is_ret_D.
// Other inputs: ret_pc_load, cnt_clr.
// Controller outputs: forward_a_E, forward_b_E, stall_F, stall_D, flush_D, flush_E, state_o, stall_cnt.
interface hazard_ctrl_seq_if #(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E;
    logic              reg_write_M, reg_write_W, use_rs_D, use_rt_D, is_2byte_D;
    logic              mem_read_E, branch_taken_E, is_ret_D, ret_pc_load, cnt_clr;
    logic [1:0]        forward_a_E, forward_b_E, state_o;
    logic              stall_F, stall_D, flush_D, flush_E;
    logic [CNT_W-1:0]  stall_cnt;
    modport master (
        output rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E, reg_write_M, reg_write_W,
               use_rs_D, use_rt_D, is_2byte_D, mem_read_E, branch_taken_E, is_ret_D,
               ret_pc_load, cnt_clr,
        input  forward_a_E, forward_b_E, state_o, stall_F, stall_D, flush_D, flush_E, stall_cnt
    );
    modport slave (
        input  rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E, reg_write_M, reg_write_W,
               use_rs_D, use_rt_D, is_2byte_D, mem_read_E, branch_taken_E, is_ret_D,
               ret_pc_load, cnt_clr,
        output forward_a_E, forward_b_E, state_o, stall_F, stall_D, flush_D, flush_E, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequential hazard controller (forwarding, stall/flush FSM, stall-cycle counter).
// Ports: clk (rising edge), rst_n (async active-low), hz (hazard_ctrl_seq_if.slave bundle:
// pipeline register addresses/enables in, forward selects, stall/flush controls, state and stall count out).
module hazard_ctrl_seq #(
    parameter int REG_AW      = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    hazard_ctrl_seq_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'b00, LOAD_WAIT = 2'b01, RET_WAIT = 2'b10, FETCH2 = 2'b11} state_t;

    state_t           state_q, state_d;
    logic [2:0]       lcnt_q, lcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_f, s_d, f_d, f_e, load_use;

    // Register match; the hard-zero register never matches anything.
    function automatic logic hit(input logic we, input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return we && (a == b) && !(ZERO_REG_EN != 0 && a == '0);
    endfunction

    // Forward selects are forced to the register file while reset is held.
    assign hz.forward_a_E = !rst_n ? 2'b00 : hit(hz.reg_write_M, hz.rd_M, hz.rs_E) ? 2'b10 :
                            hit(hz.reg_write_W, hz.rd_W, hz.rs_E) ? 2'b01 : 2'b00;
    assign hz.forward_b_E = !rst_n ? 2'b00 : hit(hz.reg_write_M, hz.rd_M, hz.rt_E) ? 2'b10 :
                            hit(hz.reg_write_W, hz.rd_W, hz.rt_E) ? 2'b01 : 2'b00;

    assign load_use = hit(hz.mem_read_E && hz.use_rs_D, hz.rd_E, hz.rs_D) ||
                      hit(hz.mem_read_E && hz.use_rt_D, hz.rd_E, hz.rt_D);

    always_comb begin
        s_f     = 1'b1;
        s_d     = 1'b1;
        f_d     = 1'b0;
        f_e     = 1'b0;
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            RET_WAIT: begin
                s_f = hz.ret_pc_load;
                f_d = 1'b1;
                state_d = hz.ret_pc_load ? RUN : RET_WAIT;
            end
            LOAD_WAIT: begin
                if (hz.branch_taken_E) begin
                    f_d     = 1'b1;
                    f_e     = 1'b1;
                    lcnt_d  = '0;
                    state_d = RUN;
                end else begin
                    s_f     = 1'b0;
                    s_d     = 1'b0;
                    f_e     = 1'b1;
                    lcnt_d  = lcnt_q - 3'd1;
                    state_d = (lcnt_q == 3'd1) ? RUN : LOAD_WAIT;
                end
            end
            default: begin
                // RUN and FETCH2 share the rules; FETCH2 ignores is_2byte_D so it cannot re-stall.
                state_d = RUN;
                if (hz.is_ret_D) begin
                    s_f     = 1'b0;
                    f_d     = 1'b1;
                    state_d = RET_WAIT;
                end else if (hz.branch_taken_E) begin
                    f_d = 1'b1;
                    f_e = 1'b1;
                end else if (hz.is_2byte_D && state_q == RUN) begin
                    s_d     = 1'b0;
                    f_e     = 1'b1;
                    state_d = FETCH2;
                end else if (load_use) begin
                    s_f = 1'b0;
                    s_d = 1'b0;
                    f_e = 1'b1;
                    if (LOAD_LAT > 1) begin
                        lcnt_d  = 3'(LOAD_LAT - 1);
                        state_d = LOAD_WAIT;
                    end
                end
            end
        endcase
        cnt_d = hz.cnt_clr ? '0 : ((!s_f || !s_d) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            lcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls fall back to their idle values immediately while reset is asserted.
    assign hz.stall_F   = s_f || !rst_n;
    assign hz.stall_D   = s_d || !rst_n;
    assign hz.flush_D   = f_d && rst_n;
    assign hz.flush_E   = f_e && rst_n;
    assign hz.state_o   = state_q;
    assign hz.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb_hazard_ctrl_seq: checks two controller configurations against a behavioural model.
// dut_a: LOAD_LAT=1, no zero register, 16-bit counter; dut_b: LOAD_LAT=3, zero register, 4-bit counter.
module tb_hazard_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E;
    logic reg_write_M, reg_write_W, use_rs_D, use_rt_D, is_2byte_D;
    logic mem_read_E, branch_taken_E, is_ret_D, ret_pc_load, cnt_clr;

    hazard_ctrl_seq_if #(.REG_AW(2), .CNT_W(16)) ia();
    hazard_ctrl_seq_if #(.REG_AW(2), .CNT_W(4))  ib();

    hazard_ctrl_seq #(.REG_AW(2), .LOAD_LAT(1), .ZERO_REG_EN(0), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .hz(ia.slave));
    hazard_ctrl_seq #(.REG_AW(2), .LOAD_LAT(3), .ZERO_REG_EN(1), .CNT_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .hz(ib.slave));

    assign {ia.rs_E, ia.rt_E, ia.rd_M, ia.rd_W, ia.rs_D, ia.rt_D, ia.rd_E} = {rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E};
    assign {ib.rs_E, ib.rt_E, ib.rd_M, ib.rd_W, ib.rs_D, ib.rt_D, ib.rd_E} = {rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E};
    assign {ia.reg_write_M, ia.reg_write_W, ia.use_rs_D, ia.use_rt_D, ia.is_2byte_D, ia.mem_read_E,
            ia.branch_taken_E, ia.is_ret_D, ia.ret_pc_load, ia.cnt_clr} =
           {reg_write_M, reg_write_W, use_rs_D, use_rt_D, is_2byte_D, mem_read_E,
            branch_taken_E, is_ret_D, ret_pc_load, cnt_clr};
    assign {ib.reg_write_M, ib.reg_write_W, ib.use_rs_D, ib.use_rt_D, ib.is_2byte_D, ib.mem_read_E,
            ib.branch_taken_E, ib.is_ret_D, ib.ret_pc_load, ib.cnt_clr} =
           {reg_write_M, reg_write_W, use_rs_D, use_rt_D, is_2byte_D, mem_read_E,
            branch_taken_E, is_ret_D, ret_pc_load, cnt_clr};

    logic [1:0]  fa[2], fb[2], st[2];
    logic        sf[2], sd[2], fd[2], fe[2];
    logic [15:0] sc[2];
    assign {fa[0], fb[0], st[0], sf[0], sd[0], fd[0], fe[0], sc[0]} =
           {ia.forward_a_E, ia.forward_b_E, ia.state_o, ia.stall_F, ia.stall_D, ia.flush_D, ia.flush_E, ia.stall_cnt};
    assign {fa[1], fb[1], st[1], sf[1], sd[1], fd[1], fe[1], sc[1]} =
           {ib.forward_a_E, ib.forward_b_E, ib.state_o, ib.stall_F, ib.stall_D, ib.flush_D, ib.flush_E, 12'b0, ib.stall_cnt};

    // Model: configuration per instance plus abstract bookkeeping
    // (remaining load stall cycles, waiting for return PC, second byte pending, stall count).
    int lat[2]  = '{1, 3};
    bit zr[2]   = '{1'b0, 1'b1};
    int cmax[2] = '{65535, 15};
    int pend[2], cnt[2];
    bit inret[2], sec[2];
    int checks = 0, failures = 0;

    function automatic bit m(int k, bit we, int a, int b);
        return we && a == b && !(zr[k] && a == 0);
    endfunction

    function automatic int fwd(int k, int a);
        if (!rst_n) return 0;
        if (m(k, reg_write_M, int'(rd_M), a)) return 2;
        if (m(k, reg_write_W, int'(rd_W), a)) return 1;
        return 0;
    endfunction

    function automatic bit lu(int k);
        return mem_read_E && (m(k, use_rs_D, int'(rd_E), int'(rs_D)) || m(k, use_rt_D, int'(rd_E), int'(rt_D)));
    endfunction

    task automatic expect_ctl(input int k, output bit e_sf, output bit e_sd, output bit e_fd, output bit e_fe);
        e_sf = 1; e_sd = 1; e_fd = 0; e_fe = 0;
        if (!rst_n) return;
        if (inret[k]) begin
            e_sf = ret_pc_load; e_fd = 1;
        end else if (pend[k] > 0) begin
            if (branch_taken_E) begin e_fd = 1; e_fe = 1; end
            else begin e_sf = 0; e_sd = 0; e_fe = 1; end
        end else if (is_ret_D) begin
            e_sf = 0; e_fd = 1;
        end else if (branch_taken_E) begin
            e_fd = 1; e_fe = 1;
        end else if (is_2byte_D && !sec[k]) begin
            e_sd = 0; e_fe = 1;
        end else if (lu(k)) begin
            e_sf = 0; e_sd = 0; e_fe = 1;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            failures++;
            $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        bit e_sf, e_sd, e_fd, e_fe;
        for (int k = 0; k < 2; k++) begin
            expect_ctl(k, e_sf, e_sd, e_fd, e_fe);
            chk("forward_a_E", k, 32'(fa[k]), fwd(k, int'(rs_E)));
            chk("forward_b_E", k, 32'(fb[k]), fwd(k, int'(rt_E)));
            chk("stall_F", k, 32'(sf[k]), int'(e_sf));
            chk("stall_D", k, 32'(sd[k]), int'(e_sd));
            chk("flush_D", k, 32'(fd[k]), int'(e_fd));
            chk("flush_E", k, 32'(fe[k]), int'(e_fe));
            chk("state_o", k, 32'(st[k]), inret[k] ? 2 : pend[k] > 0 ? 1 : sec[k] ? 3 : 0);
            chk("stall_cnt", k, 32'(sc[k]), cnt[k]);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; cnt[k] = 0; inret[k] = 0; sec[k] = 0;
        end
    endtask

    task automatic advance();
        bit e_sf, e_sd, e_fd, e_fe, was_sec;
        for (int k = 0; k < 2; k++) begin
            expect_ctl(k, e_sf, e_sd, e_fd, e_fe);
            if (cnt_clr) cnt[k] = 0;
            else if ((!e_sf || !e_sd) && cnt[k] < cmax[k]) cnt[k]++;
            was_sec = sec[k];
            sec[k] = 0;
            if (inret[k]) begin
                if (ret_pc_load) inret[k] = 0;
            end else if (pend[k] > 0) begin
                pend[k] = branch_taken_E ? 0 : pend[k] - 1;
            end else if (is_ret_D) inret[k] = 1;
            else if (branch_taken_E) ;
            else if (is_2byte_D && !was_sec) sec[k] = 1;
            else if (lu(k)) pend[k] = lat[k] - 1;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 check_all();
        @(posedge clk);
        if (rst_n) advance(); else mreset();
        @(negedge clk);
    endtask

    task automatic idle();
        {rs_E, rt_E, rd_M, rd_W, rs_D, rt_D, rd_E} = '0;
        {reg_write_M, reg_write_W, use_rs_D, use_rt_D, is_2byte_D} = '0;
        {mem_read_E, branch_taken_E, is_ret_D, ret_pc_load, cnt_clr} = '0;
    endtask

    task automatic set_load_use();
        mem_read_E = 1; rd_E = 2'd1; rs_D = 2'd1; use_rs_D = 1;
    endtask

    initial begin
        idle();
        mreset();
        rst_n = 1'b0;
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        // Forwarding: Memory over Writeback, then Writeback alone, then register 0.
        reg_write_M = 1; rd_M = 2'd2; reg_write_W = 1; rd_W = 2'd2; rs_E = 2'd2; rt_E = 2'd3;
        step();
        reg_write_M = 0; step();
        reg_write_M = 1; rd_M = 2'd0; rs_E = 2'd0; step();
        idle();
        // Load-use, one cycle of stimulus, then without use_rs_D.
        set_load_use(); step();
        idle(); repeat (4) step();
        set_load_use(); use_rs_D = 0; step();
        idle(); step();
        // Load-use interrupted by a branch on the second cycle.
        set_load_use(); step();
        idle(); branch_taken_E = 1; step();
        idle(); repeat (3) step();
        // RET released four cycles later, then a branch while waiting.
        is_ret_D = 1; step();
        idle(); repeat (3) step();
        ret_pc_load = 1; step();
        idle(); step();
        is_ret_D = 1; step();
        idle(); branch_taken_E = 1; step();
        idle(); ret_pc_load = 1; step();
        idle(); step();
        // 2-byte held two cycles, then reset in the middle of FETCH2.
        is_2byte_D = 1; step(); step();
        idle(); step();
        is_2byte_D = 1; step();
        #1 check_all();
        #1 rst_n = 1'b0;
        mreset();
        #1 check_all();
        @(negedge clk);
        idle(); step();
        rst_n = 1'b1;
        // Counter saturation and clear with a concurrent stall.
        cnt_clr = 1; step();
        cnt_clr = 0; set_load_use(); repeat (20) step();
        cnt_clr = 1; step();
        cnt_clr = 0; step();
        idle(); repeat (4) step();
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            {rs_E, rt_E, rd_M, rd_W} = 8'($urandom);
            {rs_D, rt_D, rd_E} = 6'($urandom);
            {reg_write_M, reg_write_W, use_rs_D, use_rt_D, mem_read_E} = 5'($urandom);
            is_ret_D       = ($urandom_range(0, 15) == 0);
            ret_pc_load    = ($urandom_range(0, 3) == 0);
            branch_taken_E = ($urandom_range(0, 7) == 0);
            is_2byte_D     = ($urandom_range(0, 5) == 0);
            cnt_clr        = ($urandom_range(0, 31) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
